multi_toggle_debounce: RTL and testbench

- Parametrised, multi-channel successor to the single-channel edge toggle.
- Each of NCH raw inputs (push-buttons, slide switches) passes through a 2-FF synchroniser and a stable-count debouncer. A qualified edge, of a selectable polarity, flips a per-channel latched output.
- Outputs can be force-loaded by a controller.
- Sits between board pins and control FSMs (e.g. stopwatch run/pause, lap select).

---
 rtl/multi_toggle_debounce.sv | 97 +++++++++
 tb/tb_multi_toggle_debounce.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multi_toggle_debounce.sv
// rtl/multi_toggle_debounce.sv - per-channel 2-FF sync, stable-count debounce and edge-toggled latch
// Optional MULTI_TOGGLE_RADIO_EN: a qualifying edge selects one-hot(channel) instead of flipping a bit.
module multi_toggle_debounce #(
  parameter int NCH        = 4,
  parameter int DB_CYCLES  = 4,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter int EDGE_MODE  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] in,
  input  logic           ld_valid,
  input  logic [NCH-1:0] ld_value,
  output logic [NCH-1:0] out,
  output logic [NCH-1:0] stable,
  output logic [NCH-1:0] evt
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [CW-1:0]  cnt [NCH];
  logic [NCH-1:0] accept;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic [NCH-1:0] qual;
  logic [NCH-1:0] out_nxt;

  // A channel accepts its new level on the last count of an unbroken pending run.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NCH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = accept & sync2;
  assign fall = accept & ~sync2;

  // Any mode other than 1 or 2 falls back to falling-edge qualification.
  generate
    if (EDGE_MODE == 1) begin : g_rise
      assign qual = rise;
    end else if (EDGE_MODE == 2) begin : g_both
      assign qual = rise | fall;
    end else begin : g_fall
      assign qual = fall;
    end
  endgenerate

`ifdef MULTI_TOGGLE_RADIO_EN
  logic [NCH-1:0] pick;

  // Isolate the lowest qualifying channel; re-selecting the active one deselects all.
  assign pick = qual & (~qual + NCH'(1));

  always_comb begin
    out_nxt = out;
    if (|qual) begin
      out_nxt = (|(pick & out)) ? '0 : pick;
    end
  end
`else
  assign out_nxt = out ^ qual;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= {NCH{IDLE_LEVEL}};
      sync2  <= {NCH{IDLE_LEVEL}};
      stable <= {NCH{IDLE_LEVEL}};
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      out <= '0;
      evt <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
      evt <= qual;
      out <= ld_valid ? ld_value : out_nxt;
    end
  end

endmodule

// File: tb/tb_multi_toggle_debounce.sv
// tb/tb_multi_toggle_debounce.sv - directed bench: falling-edge instance plus a both-edges instance
module tb_multi_toggle_debounce;

`ifdef MULTI_TOGGLE_RADIO_EN
  localparam bit RADIO = 1'b1;
`else
  localparam bit RADIO = 1'b0;
`endif

  logic       clk;
  logic       rst, rst_b;
  logic [3:0] in_a, in_b;
  logic       ld_a, ld_b;
  logic [3:0] ldv_a, ldv_b;
  logic [3:0] out_a, stable_a, evt_a;
  logic [3:0] out_b, stable_b, evt_b;

  int checks   = 0;
  int failures = 0;
  logic [3:0] evt_or_a, evt_or_b;
  int evt_cyc_a, evt_cyc_b;

  multi_toggle_debounce #(.NCH(4), .DB_CYCLES(4), .IDLE_LEVEL(1'b1), .EDGE_MODE(0)) dut (
    .clk(clk), .rst(rst), .in(in_a), .ld_valid(ld_a), .ld_value(ldv_a),
    .out(out_a), .stable(stable_a), .evt(evt_a)
  );

  multi_toggle_debounce #(.NCH(4), .DB_CYCLES(4), .IDLE_LEVEL(1'b1), .EDGE_MODE(2)) dut_b (
    .clk(clk), .rst(rst_b), .in(in_b), .ld_valid(ld_b), .ld_value(ldv_b),
    .out(out_b), .stable(stable_b), .evt(evt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      evt_or_a |= evt_a;
      evt_or_b |= evt_b;
      if (evt_a != 4'h0) evt_cyc_a++;
      if (evt_b != 4'h0) evt_cyc_b++;
    end
  endtask

  task automatic clear_trk;
    evt_or_a  = '0;
    evt_or_b  = '0;
    evt_cyc_a = 0;
    evt_cyc_b = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    in_a = 4'h0; in_b = 4'hf;
    ld_a = 1'b0; ld_b = 1'b0; ldv_a = '0; ldv_b = '0;
    clear_trk();

    // reset held two cycles with inputs low
    tick(1);
    check("rst1_out", out_a, 4'h0);
    check("rst1_stable", stable_a, 4'hf);
    check("rst1_evt", evt_a, 4'h0);
    tick(1);
    check("rst2_out", out_a, 4'h0);
    check("rst2_stable", stable_a, 4'hf);
    check("rst2_evt", evt_a, 4'h0);
    check("rstb_stable", stable_b, 4'hf);
    rst = 1'b0; rst_b = 1'b0; in_a = 4'hf;
    tick(2);

    // ch0 press: acceptance exactly DB_CYCLES+1 edges after first sample
    clear_trk();
    in_a = 4'b1110;
    tick(5);
    check("p0_early_stable", stable_a, 4'hf);
    check("p0_early_evt", evt_or_a, 4'h0);
    tick(1);
    check("p0_stable", stable_a, 4'b1110);
    check("p0_out", out_a, 4'b0001);
    check("p0_evt", evt_a, 4'b0001);
    tick(1);
    check("p0_evt_clr", evt_a, 4'h0);
    in_a = 4'hf;
    tick(6);
    check("r0_stable", stable_a, 4'hf);
    check("r0_out", out_a, 4'b0001);
    check("r0_evt_cycles", evt_cyc_a, 1);

    // ch1 glitch of 3 cycles rejected
    clear_trk();
    in_a = 4'b1101;
    tick(3);
    in_a = 4'hf;
    tick(8);
    check("g3_stable", stable_a, 4'hf);
    check("g3_out", out_a, 4'b0001);
    check("g3_evt", evt_or_a, 4'h0);

    // ch1 low 4 cycles accepted
    clear_trk();
    in_a = 4'b1101;
    tick(4);
    in_a = 4'hf;
    tick(12);
    check("g4_out", out_a, RADIO ? 4'b0010 : 4'b0011);
    check("g4_stable", stable_a, 4'hf);
    check("g4_evt", evt_or_a, 4'b0010);
    check("g4_evt_cycles", evt_cyc_a, 1);

    // load coincident with ch1 qualifying edge
    in_a = 4'b1101;
    tick(5);
    ld_a = 1'b1; ldv_a = 4'b1010;
    tick(1);
    check("ld_out", out_a, 4'b1010);
    check("ld_evt", evt_a, 4'b0010);
    ld_a = 1'b0;
    in_a = 4'hf;
    tick(8);
    check("ld_hold", out_a, 4'b1010);

    // ch2 and ch3 qualify together
    in_a = 4'b0011;
    tick(6);
    check("dual_evt", evt_a, 4'b1100);
    check("dual_out", out_a, RADIO ? 4'b0100 : 4'b0110);
    in_a = 4'hf;
    tick(6);

    // both-edges instance: press/release ch2 gives two events
    clear_trk();
    in_b = 4'b1011;
    tick(5);
    check("b_early_evt", evt_or_b, 4'h0);
    tick(1);
    check("b_press_evt", evt_b, 4'b0100);
    check("b_press_out", out_b, 4'b0100);
    in_b = 4'hf;
    tick(5);
    tick(1);
    check("b_rel_evt", evt_b, 4'b0100);
    check("b_rel_out", out_b, 4'b0000);
    check("b_rel_stable", stable_b, 4'hf);
    check("b_evt_cycles", evt_cyc_b, 2);

    // reset in the middle of a debounce count
    in_b = 4'b1110;
    tick(3);
    rst_b = 1'b1; in_b = 4'hf;
    tick(1);
    check("b_rst_stable", stable_b, 4'hf);
    check("b_rst_out", out_b, 4'h0);
    rst_b = 1'b0;
    clear_trk();
    tick(8);
    check("b_post_rst_evt", evt_or_b, 4'h0);
    check("b_post_rst_stable", stable_b, 4'hf);

`ifdef MULTI_TOGGLE_RADIO_EN
    in_a = 4'b0111;
    tick(6);
    check("rad_ch3", out_a, 4'b1000);
    in_a = 4'hf; tick(6);
    in_a = 4'b1110;
    tick(6);
    check("rad_ch0", out_a, 4'b0001);
    in_a = 4'hf; tick(6);
    in_a = 4'b1110;
    tick(6);
    check("rad_ch0_again", out_a, 4'b0000);
    in_a = 4'hf; tick(6);
    in_a = 4'b1001;
    tick(6);
    check("rad_dual_out", out_a, 4'b0010);
    check("rad_dual_evt", evt_a, 4'b0110);
    in_a = 4'hf; tick(6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
